// File: rtl/rep_read_mem_1w8r.sv
// One-write / eight-read memory: storage is replicated into eight banks, one per read port,
// with a shared valid bitmap that masks never-written (or reset-invalidated) entries to zero.
module rep_read_mem_1w8r #(
    parameter int BLOCKSIZE = 10,
    parameter int DWIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCKSIZE:0]   w1_addr,
    input  logic [DWIDTH-1:0]    w1_din,
    input  logic                 en_w1,
    input  logic [BLOCKSIZE:0]   r1_addr,
    input  logic [BLOCKSIZE:0]   r2_addr,
    input  logic [BLOCKSIZE:0]   r3_addr,
    input  logic [BLOCKSIZE:0]   r4_addr,
    input  logic [BLOCKSIZE:0]   r5_addr,
    input  logic [BLOCKSIZE:0]   r6_addr,
    input  logic [BLOCKSIZE:0]   r7_addr,
    input  logic [BLOCKSIZE:0]   r8_addr,
    output logic [DWIDTH-1:0]    d1,
    output logic [DWIDTH-1:0]    d2,
    output logic [DWIDTH-1:0]    d3,
    output logic [DWIDTH-1:0]    d4,
    output logic [DWIDTH-1:0]    d5,
    output logic [DWIDTH-1:0]    d6,
    output logic [DWIDTH-1:0]    d7,
    output logic [DWIDTH-1:0]    d8
);
    localparam int AW    = BLOCKSIZE + 1;
    localparam int DEPTH = 2 << BLOCKSIZE;

    logic [AW-1:0]     raddr [8];
    logic [DWIDTH-1:0] dout  [8];
    logic [DEPTH-1:0]  valid_q;

    assign raddr[0] = r1_addr;
    assign raddr[1] = r2_addr;
    assign raddr[2] = r3_addr;
    assign raddr[3] = r4_addr;
    assign raddr[4] = r5_addr;
    assign raddr[5] = r6_addr;
    assign raddr[6] = r7_addr;
    assign raddr[7] = r8_addr;

    assign d1 = dout[0];
    assign d2 = dout[1];
    assign d3 = dout[2];
    assign d4 = dout[3];
    assign d5 = dout[4];
    assign d6 = dout[5];
    assign d7 = dout[6];
    assign d8 = dout[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (en_w1) begin
            valid_q[w1_addr] <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bank
            logic [DWIDTH-1:0] mem [DEPTH];
            logic [DWIDTH-1:0] rdata_q;
            logic              hit_q;

            // RAM stays reset-free so it maps to block RAM; rst only gates the write.
            always_ff @(posedge clk) begin
                if (en_w1 && rst) begin
                    mem[w1_addr] <= w1_din;
                end
                rdata_q <= mem[raddr[gi]];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hit_q <= 1'b0;
                end else begin
                    hit_q <= valid_q[raddr[gi]];
                end
            end

            // The registered valid bit masks stale or uninitialised RAM data to zero.
            assign dout[gi] = hit_q ? rdata_q : '0;
        end
    endgenerate
endmodule

// File: tb/tb_rep_read_mem_1w8r.sv
// Bench for rep_read_mem_1w8r: directed and random traffic, expected read data queued
// from a read-first array model and popped by an independent monitor on the falling edge.
module tb_rep_read_mem_1w8r;
    localparam int BS    = 10;
    localparam int DW    = 32;
    localparam int AW    = BS + 1;
    localparam int DEPTH = 2 << BS;

    typedef struct {
        logic [DW-1:0] v [8];
        string         tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] w1_addr = '0;
    logic [DW-1:0] w1_din = '0;
    logic          en_w1 = 1'b0;
    logic [AW-1:0] r_addr [8];
    logic [DW-1:0] d_o [8];

    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_vld [DEPTH];
    exp_t          sb [$];
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    rep_read_mem_1w8r #(.BLOCKSIZE(BS), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .w1_addr(w1_addr), .w1_din(w1_din), .en_w1(en_w1),
        .r1_addr(r_addr[0]), .r2_addr(r_addr[1]), .r3_addr(r_addr[2]), .r4_addr(r_addr[3]),
        .r5_addr(r_addr[4]), .r6_addr(r_addr[5]), .r7_addr(r_addr[6]), .r8_addr(r_addr[7]),
        .d1(d_o[0]), .d2(d_o[1]), .d3(d_o[2]), .d4(d_o[3]),
        .d5(d_o[4]), .d6(d_o[5]), .d7(d_o[6]), .d8(d_o[7])
    );

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endfunction

    // Monitor: each falling edge follows exactly one rising edge for each queued entry.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int k = 0; k < 8; k++)
                check($sformatf("%s d%0d", e.tag, k + 1), d_o[k], e.v[k]);
            $display("txn %s: d1=0x%08h d8=0x%08h", e.tag, d_o[0], d_o[7]);
        end
    end

    // Issue one cycle of stimulus; called half a cycle before the rising edge.
    task automatic step(string tag, bit we, logic [AW-1:0] wa, logic [DW-1:0] wd);
        exp_t e;
        en_w1 = we; w1_addr = wa; w1_din = wd;
        for (int k = 0; k < 8; k++)
            e.v[k] = ref_vld[r_addr[k]] ? ref_mem[r_addr[k]] : '0;
        e.tag = tag;
        sb.push_back(e);
        if (we) begin
            ref_mem[wa] = wd;
            ref_vld[wa] = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    task automatic set_all(logic [AW-1:0] a);
        for (int k = 0; k < 8; k++) r_addr[k] = a;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        set_all('0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 8; k++) check("reset d", d_o[k], '0);
        rst = 1'b1;

        // Reset read-back across boundary and interior addresses.
        r_addr[0] = 11'd0;    r_addr[1] = 11'd1;    r_addr[2] = 11'd2047; r_addr[3] = 11'd1234;
        r_addr[4] = 11'd0;    r_addr[5] = 11'd1;    r_addr[6] = 11'd2047; r_addr[7] = 11'd1234;
        step("rst_readback", 1'b0, '0, '0);

        step("wr_155", 1'b1, 11'h155, 32'h0000_00A5);
        set_all(11'h155);
        step("rd_155", 1'b0, '0, '0);

        set_all(11'h000);
        step("wr_020_a", 1'b1, 11'h020, 32'h11);
        r_addr[2] = 11'h020;
        step("rf_collide", 1'b1, 11'h020, 32'h22);
        step("rf_after", 1'b0, '0, '0);

        set_all(11'h7FF);
        step("dis_wr", 1'b0, 11'h7FF, 32'hFF);
        step("dis_rd", 1'b0, '0, '0);
        step("en_wr", 1'b1, 11'h7FF, 32'hFF);
        step("en_rd", 1'b0, '0, '0);

        step("wr_full", 1'b1, 11'h000, 32'hDEAD_BEEF);
        set_all(11'h000);
        step("rd_full", 1'b0, '0, '0);

        // Mid-run asynchronous reset, with a write presented on the edge while in reset.
        step("wr_7", 1'b1, 11'd7, 32'h5A);
        set_all(11'd7);
        step("rd_7", 1'b0, '0, '0);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) check("async_rst d", d_o[k], '0);
        en_w1 = 1'b1; w1_addr = 11'd9; w1_din = 32'h77;
        for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
        @(negedge clk); #1;
        for (int k = 0; k < 8; k++) check("rst_edge d", d_o[k], '0);
        rst = 1'b1;
        r_addr[0] = 11'd9;
        step("post_rst", 1'b0, '0, '0);

        // Random soak: mostly a small address window so reads hit recent writes.
        for (int n = 0; n < 4000; n++) begin
            bit narrow;
            logic [AW-1:0] wa;
            logic [DW-1:0] wd;
            narrow = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++)
                r_addr[k] = narrow ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, DEPTH - 1));
            wa = narrow ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, DEPTH - 1));
            wd = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 255));
            step("soak", 1'($urandom_range(0, 1)), wa, wd);
        end

        en_w1 = 1'b0;
        begin
            int waited = 0;
            while (sb.size() > 0 && waited < 5) begin
                @(negedge clk); #1;
                waited++;
            end
            n_checks++;
            if (sb.size() == 0) n_pass++;
            else $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
